// File: rtl/deser_pkg.sv
// -----------------------------------------------------------------------------
// deser_pkg
// Shared constants and types for the 1:4 deserializer.
//   NUM_SLOTS  : number of samples per assembled word
//   SLOT_W     : width of the slot index
//   slot_idx_t : slot index type
//   LAST_SLOT  : index of the slot whose acceptance completes a word
//   next_slot  : modulo-4 slot increment
// -----------------------------------------------------------------------------
package deser_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;

    typedef logic [SLOT_W-1:0] slot_idx_t;

    localparam slot_idx_t LAST_SLOT = 2'd3;

    // The 2-bit slot index wraps 3 -> 0 on its own, so no explicit compare is needed.
    function automatic slot_idx_t next_slot(input slot_idx_t s);
        return s + 2'd1;
    endfunction

endpackage

// File: rtl/deser_out_reg.sv
// -----------------------------------------------------------------------------
// deser_out_reg
// Output holding stage: a valid/data register with stall.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_load       : a completed word is presented this cycle
//   i_load_data  : the completed word
//   i_ready      : downstream consumer takes the held word
//   o_valid      : o_data holds a complete word
//   o_data       : the held word
// A load on the same edge as a drain keeps o_valid high with the new word.
// -----------------------------------------------------------------------------
module deser_out_reg #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [DW-1:0] i_load_data,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data
);

    logic          r_valid;
    logic [DW-1:0] r_data;

    // Holding register: load wins over drain, otherwise hold stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_load_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/deser1_4.sv
// -----------------------------------------------------------------------------
// deser1_4
// 1:4 deserializer: collects four W-bit samples into one 4*W-bit word.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input sample handshake
//   in_data              : W-bit sample
//   in_sof               : start of frame, forces the sample into slot 0
//   out_valid/out_ready  : output word handshake
//   out_data             : assembled word, slot k at bits [k*W +: W]
//   slot                 : index of the next slot to fill
//   sync_err, err_clr    : sticky misalignment flag and its clear
// Only slots 0-2 are stored; slot 3 is taken straight from in_data when the
// word completes, so the word reaches out_data on the edge of the 4th sample.
// -----------------------------------------------------------------------------
module deser1_4
    import deser_pkg::*;
#(
    parameter int W = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_data,
    input  logic                   in_sof,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_SLOTS*W-1:0] out_data,
    output logic [SLOT_W-1:0]      slot,
    output logic                   sync_err,
    input  logic                   err_clr
);

    slot_idx_t                r_slot;
    logic [W-1:0]             r_asm [0:NUM_SLOTS-2];
    logic                     r_sync_err;

    logic                     w_accept;
    logic                     w_complete;
    logic                     w_misalign;
    logic [NUM_SLOTS*W-1:0]   w_word;

    // Stall only when the last slot would overwrite a word still waiting downstream.
    assign in_ready   = ~((r_slot == LAST_SLOT) && out_valid && ~out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_complete = w_accept && ~in_sof && (r_slot == LAST_SLOT);
    assign w_misalign = w_accept && in_sof && (r_slot != 2'd0);
    assign w_word     = {in_data, r_asm[2], r_asm[1], r_asm[0]};

    // Slot counter and assembly slots; SOF restarts the frame at slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot <= 2'd0;
            for (int k = 0; k < NUM_SLOTS - 1; k++) begin
                r_asm[k] <= '0;
            end
        end else if (w_accept) begin
            if (in_sof) begin
                r_asm[0] <= in_data;
                r_slot   <= 2'd1;
            end else begin
                case (r_slot)
                    2'd0:    r_asm[0] <= in_data;
                    2'd1:    r_asm[1] <= in_data;
                    2'd2:    r_asm[2] <= in_data;
                    default: r_asm[0] <= r_asm[0];
                endcase
                r_slot <= next_slot(r_slot);
            end
        end else begin
            r_slot <= r_slot;
        end
    end

    // Sticky misalignment flag; a new error beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_err <= 1'b0;
        end else if (w_misalign) begin
            r_sync_err <= 1'b1;
        end else if (err_clr) begin
            r_sync_err <= 1'b0;
        end else begin
            r_sync_err <= r_sync_err;
        end
    end

    deser_out_reg #(
        .DW (NUM_SLOTS * W)
    ) u_out_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_complete),
        .i_load_data (w_word),
        .i_ready     (out_ready),
        .o_valid     (out_valid),
        .o_data      (out_data)
    );

    assign slot     = r_slot;
    assign sync_err = r_sync_err;

endmodule

// File: tb/tb_deser1_4.sv
// -----------------------------------------------------------------------------
// tb_deser1_4
// Directed, table-driven bench for deser1_4 with W=4 (16-bit words).
// Each record drives one cycle; in_ready is compared before the edge and the
// registered outputs after it. Reset mid-word is a hand-written sequence.
// -----------------------------------------------------------------------------
module tb_deser1_4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic        in_sof;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  slot;
    logic        sync_err;
    logic        err_clr;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        iv;
        logic [3:0]  d;
        logic        sof;
        logic        ordy;
        logic        clr;
        logic        e_rdy;
        logic        e_ov;
        logic [15:0] e_od;
        logic [1:0]  e_slot;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    deser1_4 #(.W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .slot      (slot),
        .sync_err  (sync_err),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [3:0] d, input logic sof,
                                input logic ordy, input logic clr, input logic e_rdy,
                                input logic e_ov, input logic [15:0] e_od,
                                input logic [1:0] e_slot, input logic e_err);
        vec_t v;
        v.iv = iv; v.d = d; v.sof = sof; v.ordy = ordy; v.clr = clr;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_od = e_od; v.e_slot = e_slot; v.e_err = e_err;
        return v;
    endfunction

    // iv, d, sof, ordy, clr | in_ready(pre-edge), out_valid, out_data, slot, sync_err (post-edge)
    task automatic add(input logic iv, input logic [3:0] d, input logic sof, input logic ordy,
                       input logic clr, input logic e_rdy, input logic e_ov,
                       input logic [15:0] e_od, input logic [1:0] e_slot, input logic e_err);
        tbl.push_back(mk(iv, d, sof, ordy, clr, e_rdy, e_ov, e_od, e_slot, e_err));
    endtask

    // One cycle: drive after the falling edge, check in_ready, then outputs after the rising edge.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        in_valid  = v.iv;
        in_data   = v.d;
        in_sof    = v.sof;
        out_ready = v.ordy;
        err_clr   = v.clr;
        #1;
        chk("in_ready", idx, {15'd0, in_ready}, {15'd0, v.e_rdy});
        @(posedge clk);
        #1;
        chk("out_valid", idx, {15'd0, out_valid}, {15'd0, v.e_ov});
        chk("slot", idx, {14'd0, slot}, {14'd0, v.e_slot});
        chk("sync_err", idx, {15'd0, sync_err}, {15'd0, v.e_err});
        if (v.e_ov) begin
            chk("out_data", idx, out_data, v.e_od);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        in_sof    = 1'b0;
        out_ready = 1'b0;
        err_clr   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 0, {15'd0, out_valid}, 16'd0);
        chk("rst_out_data", 0, out_data, 16'd0);
        chk("rst_slot", 0, {14'd0, slot}, 16'd0);
        chk("rst_sync_err", 0, {15'd0, sync_err}, 16'd0);
        chk("rst_in_ready", 0, {15'd0, in_ready}, 16'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Steady stream 1,2,3,4 -> 16'h4321
        add(1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd1, 1'b0);
        add(1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd2, 1'b0);
        add(1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd3, 1'b0);
        add(1'b1, 4'h4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h4321, 2'd0, 1'b0);
        add(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0);
        // Backpressure A..F,0,1 with out_ready low -> DCBA held, stall at slot 3
        add(1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd1, 1'b0);
        add(1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd2, 1'b0);
        add(1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd3, 1'b0);
        add(1'b1, 4'hD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hDCBA, 2'd0, 1'b0);
        add(1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hDCBA, 2'd1, 1'b0);
        add(1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hDCBA, 2'd2, 1'b0);
        add(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hDCBA, 2'd3, 1'b0);
        add(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hDCBA, 2'd3, 1'b0);
        add(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hDCBA, 2'd3, 1'b0);
        // out_ready rises: drain and completion on the same edge -> 16'h10FE
        add(1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h10FE, 2'd0, 1'b0);
        add(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0);
        // Resync: 1,2 then 5 with SOF, 6,7,8 -> 16'h8765, sync_err set
        add(1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd1, 1'b0);
        add(1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd2, 1'b0);
        add(1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd1, 1'b1);
        add(1'b1, 4'h6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd2, 1'b1);
        add(1'b1, 4'h7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd3, 1'b1);
        add(1'b1, 4'h8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h8765, 2'd0, 1'b1);
        add(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b1);
        // Error clearing, then clear coincident with a new misaligned SOF
        add(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0);
        add(1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd1, 1'b0);
        add(1'b1, 4'h2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 2'd1, 1'b1);
        add(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 2'd1, 1'b0);
        add(1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd2, 1'b0);
        add(1'b1, 4'h4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd3, 1'b0);
        add(1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h5432, 2'd0, 1'b0);
        add(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0);
        // Aligned SOF at slot 0 raises no error
        add(1'b1, 4'h7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd1, 1'b0);
        add(1'b1, 4'h8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd2, 1'b0);
        add(1'b1, 4'h9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd3, 1'b0);
        add(1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'hA987, 2'd0, 1'b0);
        // Back-to-back words: one word every 4 cycles, no bubbles
        add(1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd1, 1'b0);
        add(1'b1, 4'h6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd2, 1'b0);
        add(1'b1, 4'h7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd3, 1'b0);
        add(1'b1, 4'h8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h8765, 2'd0, 1'b0);
        add(1'b1, 4'h9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd1, 1'b0);
        add(1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd2, 1'b0);
        add(1'b1, 4'hB, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd3, 1'b0);
        add(1'b1, 4'hC, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'hCBA9, 2'd0, 1'b0);
        add(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i + 1);
        end

        // Reset mid-word: pending word 4321 plus two samples in slots 0-1
        apply(mk(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd1, 1'b0), 101);
        apply(mk(1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd2, 1'b0), 102);
        apply(mk(1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd3, 1'b0), 103);
        apply(mk(1'b1, 4'h4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h4321, 2'd0, 1'b0), 104);
        apply(mk(1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h4321, 2'd1, 1'b0), 105);
        apply(mk(1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h4321, 2'd2, 1'b0), 106);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 107, {15'd0, out_valid}, 16'd0);
        chk("async_rst_out_data", 107, out_data, 16'd0);
        chk("async_rst_slot", 107, {14'd0, slot}, 16'd0);
        chk("async_rst_sync_err", 107, {15'd0, sync_err}, 16'd0);
        chk("async_rst_in_ready", 107, {15'd0, in_ready}, 16'd1);
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(1'b1, 4'hB, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd1, 1'b0), 108);
        apply(mk(1'b1, 4'hC, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd2, 1'b0), 109);
        apply(mk(1'b1, 4'hD, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd3, 1'b0), 110);
        apply(mk(1'b1, 4'hE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'hEDCB, 2'd0, 1'b0), 111);
        apply(mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0), 112);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
